// File: rtl/layer_engine_activator_sequencer_pkg.sv
// Shared definitions for the activator sequencer: FSM state encoding, opcode
// field placement and watchdog sizing.
package layer_engine_activator_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ISSUE  = 5'b00010,
    ST_STREAM = 5'b00100,
    ST_DRAIN  = 5'b01000,
    ST_DONE   = 5'b10000
  } seq_state_e;

  // Bit position of the input-count field inside the activator opcode.
  localparam int unsigned ACT_NUM_INPUTS_LSB = 0;

  function automatic int unsigned wd_width(input int unsigned timeout_cycles);
    return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/layer_engine_activator_sequencer_skid.sv
// Two-entry skid buffer with registered valid/ready; sits on the activator
// return path so the sink never sees combinational paths from the activator.
module stream_skid_buffer
  import layer_engine_activator_sequencer_pkg::*;
#(
  parameter int unsigned C_WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [C_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [C_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               empty
);

  logic [C_WIDTH-1:0] out_q;
  logic [C_WIDTH-1:0] skid_q;
  logic               out_vld_q;
  logic               skid_vld_q;

  assign in_ready  = !skid_vld_q;
  assign out_data  = out_q;
  assign out_valid = out_vld_q;
  assign empty     = !out_vld_q && !skid_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_ready || !out_vld_q) begin
      // Output slot frees up: refill from the skid entry first to keep order.
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= in_valid;
        if (in_valid) begin
          out_q <= in_data;
        end
      end
    end else if (in_valid && !skid_vld_q) begin
      skid_q     <= in_data;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/layer_engine_activator_sequencer.sv
// Job initiator for layer_engine_activator: issues the opcode, streams source
// beats in, collects activated beats into the sink and signals completion.
module layer_engine_activator_sequencer
  import layer_engine_activator_sequencer_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH     = 128,
  parameter int unsigned C_OPCODE_WIDTH   = 64,
  parameter int unsigned C_COUNT_WIDTH    = 16,
  parameter int unsigned C_TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_COUNT_WIDTH-1:0]  job_num_inputs,
  input  logic                      job_valid,
  output logic                      job_ready,
  output logic                      job_done,
  output logic                      job_error,
  output logic [C_OPCODE_WIDTH-1:0] opcode,
  output logic                      opcode_valid,
  input  logic                      opcode_accept,
  input  logic [C_DATA_WIDTH-1:0]   src_data,
  input  logic                      src_valid,
  output logic                      src_ready,
  output logic [C_DATA_WIDTH-1:0]   act_datain,
  output logic                      act_datain_valid,
  input  logic                      act_datain_ready,
  input  logic [C_DATA_WIDTH-1:0]   act_dataout,
  input  logic                      act_dataout_valid,
  output logic                      act_dataout_ready,
  output logic [C_DATA_WIDTH-1:0]   snk_data,
  output logic                      snk_valid,
  input  logic                      snk_ready
);

  localparam int unsigned CW   = C_COUNT_WIDTH;
  localparam int unsigned WD_W = wd_width(C_TIMEOUT_CYCLES);

  seq_state_e      state_q, state_d;
  logic            rst_sync_q;
  logic [CW-1:0]   cnt_q, sent_q, recv_q;
  logic [CW-1:0]   sent_nxt, recv_nxt;
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            in_stream, in_return;
  logic            sent_lt, recv_lt;
  logic            fwd_hs, ret_hs, job_hs;
  logic            skid_in_ready, skid_empty;
  logic            wd_expired, timeout_hit;

  // Single-flop release synchroniser: assertion stays asynchronous, release is
  // aligned to clk, which makes job_ready rise one cycle after rst_n goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  assign in_stream = (state_q == ST_STREAM);
  assign in_return = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign sent_lt   = (sent_q < cnt_q);
  assign recv_lt   = (recv_q < cnt_q);

  assign act_datain        = in_stream ? src_data : '0;
  assign act_datain_valid  = in_stream && src_valid && sent_lt;
  assign src_ready         = in_stream && act_datain_ready && sent_lt;
  assign fwd_hs            = act_datain_valid && act_datain_ready;
  assign act_dataout_ready = in_return && skid_in_ready && recv_lt;
  assign ret_hs            = act_dataout_valid && act_dataout_ready;

  assign job_ready    = rst_sync_q && (state_q == ST_IDLE) && skid_empty;
  assign job_hs       = job_valid && job_ready;
  assign opcode_valid = (state_q == ST_ISSUE) && (cnt_q != '0);
  assign job_done     = (state_q == ST_DONE);
  assign job_error    = (state_q == ST_DONE) && err_q;

  always_comb begin
    opcode = '0;
    opcode[ACT_NUM_INPUTS_LSB +: C_COUNT_WIDTH] = cnt_q;
  end

  assign wd_expired = (C_TIMEOUT_CYCLES != 0) && !ret_hs &&
                      (wd_q == WD_W'(C_TIMEOUT_CYCLES - 1));

  always_comb begin
    sent_nxt = sent_q;
    recv_nxt = recv_q;
    if (fwd_hs) begin
      sent_nxt = sent_q + CW'(1);
    end
    if (ret_hs) begin
      recv_nxt = recv_q + CW'(1);
    end
  end

  // A zero-length job still passes through ISSUE (without raising
  // opcode_valid) so every job has the same handshake-to-done skeleton.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (job_hs) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (opcode_accept) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (sent_nxt == cnt_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (recv_nxt == cnt_q) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DONE) begin
        cnt_q  <= '0;
        sent_q <= '0;
        recv_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (job_hs) begin
          cnt_q <= job_num_inputs;
        end
        sent_q <= sent_nxt;
        recv_q <= recv_nxt;
        err_q  <= err_q || timeout_hit;
      end
      // Idle-cycle watchdog: only runs while waiting for results.
      if ((state_q == ST_DRAIN) && !ret_hs) begin
        wd_q <= wd_q + WD_W'(1);
      end else begin
        wd_q <= '0;
      end
    end
  end

  stream_skid_buffer #(
    .C_WIDTH (C_DATA_WIDTH)
  ) u_ret_skid (
    .clk       (clk),
    .rst_n     (rst_sync_q),
    .in_data   (act_dataout),
    .in_valid  (ret_hs),
    .in_ready  (skid_in_ready),
    .out_data  (snk_data),
    .out_valid (snk_valid),
    .out_ready (snk_ready),
    .empty     (skid_empty)
  );

endmodule

// File: tb/tb_layer_engine_activator_sequencer.sv
// Directed-random bench for layer_engine_activator_sequencer with a queue-based
// model of the activator and of the expected sink stream.
module tb_layer_engine_activator_sequencer;

  localparam int unsigned W  = 128;
  localparam int unsigned OW = 64;
  localparam int unsigned CW = 16;
  localparam logic [W-1:0] ACT_KEY = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] job_num_inputs;
  logic          job_valid;
  logic          job_ready, job_done, job_error;
  logic [OW-1:0] opcode;
  logic          opcode_valid, opcode_accept;
  logic [W-1:0]  src_data;
  logic          src_valid, src_ready;
  logic [W-1:0]  act_datain;
  logic          act_datain_valid, act_datain_ready;
  logic [W-1:0]  act_dataout;
  logic          act_dataout_valid, act_dataout_ready;
  logic [W-1:0]  snk_data;
  logic          snk_valid, snk_ready;

  layer_engine_activator_sequencer #(
    .C_DATA_WIDTH     (W),
    .C_OPCODE_WIDTH   (OW),
    .C_COUNT_WIDTH    (CW),
    .C_TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .job_num_inputs    (job_num_inputs),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_done          (job_done),
    .job_error         (job_error),
    .opcode            (opcode),
    .opcode_valid      (opcode_valid),
    .opcode_accept     (opcode_accept),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .act_datain        (act_datain),
    .act_datain_valid  (act_datain_valid),
    .act_datain_ready  (act_datain_ready),
    .act_dataout       (act_dataout),
    .act_dataout_valid (act_dataout_valid),
    .act_dataout_ready (act_dataout_ready),
    .snk_data          (snk_data),
    .snk_valid         (snk_valid),
    .snk_ready         (snk_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [W-1:0] exp_snk[$];
  logic [W-1:0] act_q[$];
  logic [W-1:0] ret_data, src_cur;
  bit           ret_pres, ret_is_junk, job_taken;
  int           cur_n, acc_delay, ret_limit;
  bit           extra_beat;
  int           p_src, p_dready, p_ret, p_snk;
  int           fwd_n, ret_n, snk_n, ov_cycles, done_cycles, err_cycles;
  int           hs_cyc, done_cyc, err_cyc, last_ret_cyc, last_fwd_cyc;

  function automatic logic [W-1:0] act_fn(input logic [W-1:0] x);
    return {x[63:0], x[127:64]} ^ ACT_KEY;
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (job_taken) begin
      job_valid = 1'b0;
      job_taken = 1'b0;
    end
    src_data         = src_cur;
    src_valid        = ($urandom_range(99) < p_src);
    act_datain_ready = ($urandom_range(99) < p_dready);
    snk_ready        = ($urandom_range(99) < p_snk);
    if (!ret_pres) begin
      if (act_q.size() > 0 && ret_n < ret_limit && $urandom_range(99) < p_ret) begin
        ret_pres    = 1'b1;
        ret_is_junk = 1'b0;
        ret_data    = act_q[0];
      end else if (extra_beat && act_q.size() == 0 && ret_n == cur_n && cur_n > 0) begin
        ret_pres    = 1'b1;
        ret_is_junk = 1'b1;
        ret_data    = rand128();
      end
    end
    act_dataout_valid = ret_pres;
    act_dataout       = ret_data;
    opcode_accept     = 1'b0;
    if (opcode_valid) begin
      ov_cycles++;
      chk("opcode_value", W'(opcode), W'(cur_n));
      if (ov_cycles == acc_delay) opcode_accept = 1'b1;
    end
  endtask

  task automatic sample();
    if (job_valid && job_ready) begin
      hs_cyc    = cyc;
      job_taken = 1'b1;
    end
    chk("fwd_pairing", W'(act_datain_valid && act_datain_ready), W'(src_valid && src_ready));
    if (act_datain_valid) chk("fwd_data", act_datain, src_data);
    if (src_valid && src_ready) begin
      exp_snk.push_back(act_fn(src_data));
      fwd_n++;
      last_fwd_cyc = cyc;
      src_cur = rand128();
    end
    if (act_datain_valid && act_datain_ready) act_q.push_back(act_fn(act_datain));
    if (ret_is_junk && ret_pres) chk("extra_beat_ready", W'(act_dataout_ready), W'(0));
    if (act_dataout_valid && act_dataout_ready) begin
      if (!ret_is_junk && act_q.size() > 0) void'(act_q.pop_front());
      ret_pres = 1'b0;
      ret_n++;
      last_ret_cyc = cyc;
    end
    if (snk_valid && snk_ready) begin
      snk_n++;
      if (exp_snk.size() == 0) chk("snk_unexpected_beat", W'(1), W'(0));
      else chk("snk_data", snk_data, exp_snk.pop_front());
    end
    if (job_done) begin
      done_cycles++;
      done_cyc = cyc;
    end
    if (job_error) begin
      err_cycles++;
      err_cyc = cyc;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_env();
    exp_snk.delete();
    act_q.delete();
    ret_pres = 1'b0; ret_is_junk = 1'b0; job_taken = 1'b0;
    act_dataout_valid = 1'b0; src_valid = 1'b0; opcode_accept = 1'b0;
    job_valid = 1'b0;
  endtask

  task automatic run_job(input int n, input int acc, input int rlim, input bit extra,
                         input int ps, input int pd, input int pr, input int pk,
                         input bit exp_err);
    bit finished;
    int exp_ret, last_evt;
    cur_n = n; acc_delay = acc; ret_limit = rlim; extra_beat = extra;
    p_src = ps; p_dready = pd; p_ret = pr; p_snk = pk;
    fwd_n = 0; ret_n = 0; snk_n = 0; ov_cycles = 0; done_cycles = 0; err_cycles = 0;
    hs_cyc = -1; done_cyc = -1; err_cyc = -2; last_ret_cyc = -1; last_fwd_cyc = -1;
    job_num_inputs = CW'(n);
    job_valid = 1'b1;
    finished = 1'b0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      cycle();
      if (done_cycles > 0 && job_ready) finished = 1'b1;
    end
    chk("job_completes_in_budget", W'(finished), W'(1));
    for (int i = 0; i < 3; i++) cycle();
    exp_ret = (rlim < n) ? rlim : n;
    chk("job_handshake_seen", W'(hs_cyc >= 0), W'(1));
    chk("done_pulse_width", W'(done_cycles), W'(1));
    chk("error_pulse_count", W'(err_cycles), W'(exp_err));
    chk("opcode_valid_cycles", W'(ov_cycles), W'((n == 0) ? 0 : acc));
    chk("forwarded_count", W'(fwd_n), W'(n));
    chk("returned_count", W'(ret_n), W'(exp_ret));
    chk("sink_count", W'(snk_n), W'(exp_ret));
    chk("job_ready_after_job", W'(job_ready), W'(1));
    if (n == 0) chk("zero_job_done_latency", W'(done_cyc - hs_cyc), W'(2));
    if (exp_err) begin
      last_evt = (last_ret_cyc > last_fwd_cyc) ? last_ret_cyc : last_fwd_cyc;
      chk("timeout_latency", W'(done_cyc - last_evt), W'(17));
      chk("error_with_done", W'(err_cyc), W'(done_cyc));
    end else begin
      chk("sink_queue_drained", W'(exp_snk.size()), W'(0));
    end
    clear_env();
  endtask

  task automatic chk_outputs_idle(input string tag);
    chk({tag, "_job_ready"}, W'(job_ready), W'(0));
    chk({tag, "_job_done"}, W'(job_done), W'(0));
    chk({tag, "_job_error"}, W'(job_error), W'(0));
    chk({tag, "_opcode"}, W'(opcode), W'(0));
    chk({tag, "_opcode_valid"}, W'(opcode_valid), W'(0));
    chk({tag, "_src_ready"}, W'(src_ready), W'(0));
    chk({tag, "_act_datain"}, act_datain, W'(0));
    chk({tag, "_act_datain_valid"}, W'(act_datain_valid), W'(0));
    chk({tag, "_act_dataout_ready"}, W'(act_dataout_ready), W'(0));
    chk({tag, "_snk_data"}, snk_data, W'(0));
    chk({tag, "_snk_valid"}, W'(snk_valid), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit reached;
    rst_n = 1'b0;
    job_num_inputs = '0; job_valid = 1'b0; opcode_accept = 1'b0;
    src_data = '0; src_valid = 1'b0; act_datain_ready = 1'b0;
    act_dataout = '0; act_dataout_valid = 1'b0; snk_ready = 1'b0;
    src_cur = rand128(); ret_data = '0;
    clear_env();

    // Reset state and release timing.
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_idle("reset");
    rst_n = 1'b1;
    #1;
    chk("job_ready_at_release", W'(job_ready), W'(0));
    @(posedge clk);
    #1;
    chk("job_ready_one_cycle_after_release", W'(job_ready), W'(1));

    // Basic job: opcode accepted on third cycle, everything flowing.
    run_job(4, 3, 4, 1'b0, 100, 100, 100, 100, 1'b0);
    // Zero-length job.
    run_job(0, 3, 0, 1'b0, 100, 100, 100, 100, 1'b0);
    // Random stalls on every interface.
    run_job(8, 2, 8, 1'b0, 60, 60, 60, 75, 1'b0);
    run_job(8, 1, 8, 1'b0, 50, 70, 70, 80, 1'b0);
    // Activator returns only two of three results.
    run_job(3, 1, 2, 1'b0, 100, 100, 100, 100, 1'b1);
    // Activator offers a fifth beat for a four-beat job.
    run_job(4, 2, 4, 1'b1, 100, 100, 100, 100, 1'b0);

    // Reset in the middle of streaming a five-beat job.
    cur_n = 5; acc_delay = 1; ret_limit = 0; extra_beat = 1'b0;
    p_src = 100; p_dready = 100; p_ret = 0; p_snk = 0;
    fwd_n = 0; ret_n = 0; snk_n = 0; ov_cycles = 0; done_cycles = 0; err_cycles = 0;
    job_num_inputs = CW'(5);
    job_valid = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle();
      if (fwd_n == 2) reached = 1'b1;
    end
    chk("mid_job_two_beats_forwarded", W'(reached), W'(1));
    src_valid = 1'b1;
    act_datain_ready = 1'b1;
    job_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_outputs_idle("midreset");
    chk("midreset_no_done", W'(done_cycles), W'(0));
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    run_job(2, 2, 2, 1'b0, 100, 100, 100, 100, 1'b0);
    run_job(6, 4, 6, 1'b0, 70, 70, 70, 80, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
